// File: rtl/adc_burst_pkg.sv
// Shared defaults and per-channel state encoding for the multi-channel ADC burst counter.
package adc_burst_pkg;

    localparam int DEF_NUM_CHAN = 5;
    localparam int DEF_CNT_W    = 21;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } chan_state_e;

endpackage

// File: rtl/adc_burst_cntr_ch.sv
// One ADC channel burst down-counter: loads on init, decrements on enable, registered at_zero/overrun.
// Single-cycle update; no backpressure, init overrides a same-cycle enable.
module adc_burst_cntr_ch
    import adc_burst_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_init,
    input  logic             i_chan_en,
    input  logic [CNT_W-1:0] i_num,
    input  logic             i_enable,
    output logic             o_at_zero,
    output logic             o_overrun,
`ifdef BURST_CNT_READBACK_EN
    output logic [CNT_W-1:0] o_cnt,
`endif
    output chan_state_e      o_state
);

    logic [CNT_W-1:0] r_cnt;
    chan_state_e      r_state;
    logic             r_at_zero;
    logic             r_overrun;
    logic [CNT_W-1:0] w_cnt_dec;

    assign w_cnt_dec = r_cnt - CNT_W'(1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_state   <= ST_IDLE;
            r_at_zero <= 1'b1;
            r_overrun <= 1'b0;
        end else if (i_init) begin
            r_overrun <= 1'b0;
            if (i_chan_en && (i_num != '0)) begin
                r_cnt     <= i_num;
                r_state   <= ST_COUNT;
                r_at_zero <= 1'b0;
            end else begin
                r_cnt     <= '0;
                r_state   <= i_chan_en ? ST_DONE : ST_IDLE;
                r_at_zero <= 1'b1;
            end
        end else if (i_enable) begin
            // COUNT always holds a non-zero count, so the decrement cannot wrap.
            if (r_state == ST_COUNT) begin
                r_cnt     <= w_cnt_dec;
                r_at_zero <= (w_cnt_dec == '0);
                if (w_cnt_dec == '0)
                    r_state <= ST_DONE;
            end else begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_at_zero = r_at_zero;
    assign o_overrun = r_overrun;
    assign o_state   = r_state;
`ifdef BURST_CNT_READBACK_EN
    assign o_cnt     = r_cnt;
`endif

endmodule

// File: rtl/adc_burst_cntr_mc.sv
// Multi-channel ADC burst counter with armed-mask fill_done pulse (1 cycle after last channel DONE).
// No backpressure; optional count readback (1-cycle latency) when BURST_CNT_READBACK_EN is defined.
module adc_burst_cntr_mc
    import adc_burst_pkg::*;
#(
    parameter int NUM_CHAN = DEF_NUM_CHAN,
    parameter int CNT_W    = DEF_CNT_W,
    localparam int SEL_W   = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CNT_W-1:0]    num_fill_bursts,
    input  logic [NUM_CHAN-1:0] chan_en,
    input  logic                init,
    input  logic [NUM_CHAN-1:0] enable,
`ifdef BURST_CNT_READBACK_EN
    input  logic [SEL_W-1:0]    cnt_sel,
    output logic [CNT_W-1:0]    cnt_rd,
`endif
    output logic [NUM_CHAN-1:0] at_zero,
    output logic                fill_done,
    output logic [NUM_CHAN-1:0] overrun
);

    chan_state_e         w_state [NUM_CHAN];
    logic [NUM_CHAN-1:0] w_done;
    logic [NUM_CHAN-1:0] r_armed;
    logic                r_pending;
    logic                r_fill_done;
    logic                w_all_done;
`ifdef BURST_CNT_READBACK_EN
    logic [CNT_W-1:0]    w_cnt [NUM_CHAN];
    logic [CNT_W-1:0]    r_cnt_rd;
`endif

    for (genvar g = 0; g < NUM_CHAN; g++) begin : g_ch
        adc_burst_cntr_ch #(.CNT_W(CNT_W)) u_ch (
            .i_clk     (clk),
            .i_rst     (rst),
            .i_init    (init),
            .i_chan_en (chan_en[g]),
            .i_num     (num_fill_bursts),
            .i_enable  (enable[g]),
            .o_at_zero (at_zero[g]),
            .o_overrun (overrun[g]),
`ifdef BURST_CNT_READBACK_EN
            .o_cnt     (w_cnt[g]),
`endif
            .o_state   (w_state[g])
        );
        assign w_done[g] = (w_state[g] == ST_DONE);
    end

    // r_pending is only set by an init with a non-empty mask, so an empty mask never pulses.
    assign w_all_done = r_pending && ((w_done & r_armed) == r_armed);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed     <= '0;
            r_pending   <= 1'b0;
            r_fill_done <= 1'b0;
        end else if (init) begin
            r_armed     <= chan_en;
            r_pending   <= |chan_en;
            r_fill_done <= 1'b0;
        end else begin
            r_fill_done <= w_all_done;
            if (w_all_done)
                r_pending <= 1'b0;
        end
    end

    assign fill_done = r_fill_done;

`ifdef BURST_CNT_READBACK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt_rd <= '0;
        else if (int'(cnt_sel) < NUM_CHAN)
            r_cnt_rd <= w_cnt[cnt_sel];
        else
            r_cnt_rd <= '0;
    end

    assign cnt_rd = r_cnt_rd;
`endif

endmodule

// File: tb/tb_adc_burst_cntr_mc.sv
// Directed self-checking bench for adc_burst_cntr_mc (readback checks only when BURST_CNT_READBACK_EN is defined).
module tb_adc_burst_cntr_mc;

    localparam int NC = 5;
    localparam int CW = 21;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] num_fill_bursts;
    logic [NC-1:0] chan_en;
    logic          init;
    logic [NC-1:0] enable;
    logic [NC-1:0] at_zero;
    logic          fill_done;
    logic [NC-1:0] overrun;
`ifdef BURST_CNT_READBACK_EN
    logic [2:0]    cnt_sel;
    logic [CW-1:0] cnt_rd;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    adc_burst_cntr_mc #(.NUM_CHAN(NC), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .num_fill_bursts (num_fill_bursts),
        .chan_en         (chan_en),
        .init            (init),
        .enable          (enable),
`ifdef BURST_CNT_READBACK_EN
        .cnt_sel         (cnt_sel),
        .cnt_rd          (cnt_rd),
`endif
        .at_zero         (at_zero),
        .fill_done       (fill_done),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns past it before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_init(input logic [CW-1:0] num, input logic [NC-1:0] en);
        num_fill_bursts = num;
        chan_en         = en;
        init            = 1'b1;
        tick();
        init            = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; init = 1'b0; enable = '0; chan_en = '0; num_fill_bursts = '0;
`ifdef BURST_CNT_READBACK_EN
        cnt_sel = '0;
`endif
        #12;
        n_checks++;
        if (at_zero !== 5'b11111) begin n_fail++; $display("FAIL reset_at_zero got %b exp 11111", at_zero); end
        n_checks++;
        if (fill_done !== 1'b0) begin n_fail++; $display("FAIL reset_fill_done got %b exp 0", fill_done); end
        n_checks++;
        if (overrun !== 5'b00000) begin n_fail++; $display("FAIL reset_overrun got %b exp 00000", overrun); end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_channel();
        do_init(21'd3, 5'b00001);
        n_checks++;
        if (at_zero !== 5'b11110) begin n_fail++; $display("FAIL single_loaded at_zero got %b exp 11110", at_zero); end
        enable = 5'b00001;
        tick(); tick();
        n_checks++;
        if (at_zero !== 5'b11110) begin n_fail++; $display("FAIL single_two_dec at_zero got %b exp 11110", at_zero); end
        tick();
        enable = '0;
        n_checks++;
        if (at_zero !== 5'b11111) begin n_fail++; $display("FAIL single_third_dec at_zero got %b exp 11111", at_zero); end
        n_checks++;
        if (fill_done !== 1'b0) begin n_fail++; $display("FAIL single_fd_early got %b exp 0", fill_done); end
        tick();
        n_checks++;
        if (fill_done !== 1'b1) begin n_fail++; $display("FAIL single_fd_pulse got %b exp 1", fill_done); end
        tick();
        n_checks++;
        if (fill_done !== 1'b0) begin n_fail++; $display("FAIL single_fd_once got %b exp 0", fill_done); end
        n_checks++;
        if (overrun !== 5'b00000) begin n_fail++; $display("FAIL single_overrun got %b exp 00000", overrun); end
    endtask

    task automatic test_overrun();
        enable = 5'b00001;
        tick();
        enable = '0;
        n_checks++;
        if (overrun !== 5'b00001) begin n_fail++; $display("FAIL overrun_set got %b exp 00001", overrun); end
        n_checks++;
        if (at_zero !== 5'b11111) begin n_fail++; $display("FAIL overrun_at_zero got %b exp 11111", at_zero); end
        tick(); tick();
        n_checks++;
        if (overrun !== 5'b00001) begin n_fail++; $display("FAIL overrun_sticky got %b exp 00001", overrun); end
        n_checks++;
        if (fill_done !== 1'b0) begin n_fail++; $display("FAIL overrun_no_fd got %b exp 0", fill_done); end
    endtask

    task automatic test_zero_load();
        do_init(21'd0, 5'b11111);
        n_checks++;
        if (overrun !== 5'b00000) begin n_fail++; $display("FAIL zero_overrun_clr got %b exp 00000", overrun); end
        n_checks++;
        if (at_zero !== 5'b11111) begin n_fail++; $display("FAIL zero_at_zero got %b exp 11111", at_zero); end
        n_checks++;
        if (fill_done !== 1'b0) begin n_fail++; $display("FAIL zero_fd_early got %b exp 0", fill_done); end
        tick();
        n_checks++;
        if (fill_done !== 1'b1) begin n_fail++; $display("FAIL zero_fd_pulse got %b exp 1", fill_done); end
        tick();
        n_checks++;
        if (fill_done !== 1'b0) begin n_fail++; $display("FAIL zero_fd_once got %b exp 0", fill_done); end
    endtask

    task automatic test_two_channel();
        do_init(21'd2, 5'b00011);
        n_checks++;
        if (at_zero !== 5'b11100) begin n_fail++; $display("FAIL two_loaded at_zero got %b exp 11100", at_zero); end
        enable = 5'b11101;
        tick(); tick();
        enable = '0;
        n_checks++;
        if (at_zero !== 5'b11101) begin n_fail++; $display("FAIL two_ch0_done at_zero got %b exp 11101", at_zero); end
        n_checks++;
        if (overrun !== 5'b11100) begin n_fail++; $display("FAIL two_idle_overrun got %b exp 11100", overrun); end
        enable = 5'b00010;
        tick();
        n_checks++;
        if (fill_done !== 1'b0) begin n_fail++; $display("FAIL two_fd_partial got %b exp 0", fill_done); end
        tick();
        enable = '0;
        n_checks++;
        if (at_zero !== 5'b11111) begin n_fail++; $display("FAIL two_ch1_done at_zero got %b exp 11111", at_zero); end
        n_checks++;
        if (fill_done !== 1'b0) begin n_fail++; $display("FAIL two_fd_early got %b exp 0", fill_done); end
        tick();
        n_checks++;
        if (fill_done !== 1'b1) begin n_fail++; $display("FAIL two_fd_pulse got %b exp 1", fill_done); end
        n_checks++;
        if (overrun !== 5'b11100) begin n_fail++; $display("FAIL two_overrun_hold got %b exp 11100", overrun); end
    endtask

    task automatic test_init_collision();
        do_init(21'd5, 5'b00001);
        enable          = 5'b00001;
        num_fill_bursts = 21'd7;
        init            = 1'b1;
        tick();
        init            = 1'b0;
        // Reload to 7 with the same-cycle decrement dropped: six more keep it non-zero.
        for (int k = 0; k < 6; k++) tick();
        n_checks++;
        if (at_zero[0] !== 1'b0) begin n_fail++; $display("FAIL coll_six_dec at_zero0 got %b exp 0", at_zero[0]); end
        n_checks++;
        if (fill_done !== 1'b0) begin n_fail++; $display("FAIL coll_no_fd got %b exp 0", fill_done); end
        tick();
        enable = '0;
        n_checks++;
        if (at_zero[0] !== 1'b1) begin n_fail++; $display("FAIL coll_seventh_dec at_zero0 got %b exp 1", at_zero[0]); end
        tick();
        n_checks++;
        if (fill_done !== 1'b1) begin n_fail++; $display("FAIL coll_fd_pulse got %b exp 1", fill_done); end
    endtask

    task automatic test_abort_and_async_reset();
        do_init(21'd4, 5'b11111);
        enable = 5'b11111;
        tick();
        enable = '0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (at_zero !== 5'b11111) begin n_fail++; $display("FAIL async_rst_at_zero got %b exp 11111", at_zero); end
        n_checks++;
        if (fill_done !== 1'b0) begin n_fail++; $display("FAIL async_rst_fd got %b exp 0", fill_done); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        do_init(21'd1, 5'b00000);
        tick(); tick();
        n_checks++;
        if (fill_done !== 1'b0) begin n_fail++; $display("FAIL empty_mask_fd got %b exp 0", fill_done); end
        n_checks++;
        if (at_zero !== 5'b11111) begin n_fail++; $display("FAIL empty_mask_at_zero got %b exp 11111", at_zero); end
    endtask

    task automatic test_max_count();
        do_init(21'h1F_FFFF, 5'b00001);
        enable = 5'b00001;
        tick();
        enable = '0;
        n_checks++;
        if (at_zero[0] !== 1'b0) begin n_fail++; $display("FAIL max_at_zero0 got %b exp 0", at_zero[0]); end
`ifdef BURST_CNT_READBACK_EN
        cnt_sel = 3'd0;
        do_init(21'h1F_FFFF, 5'b00001);
        tick();
        n_checks++;
        if (cnt_rd !== 21'h1F_FFFF) begin n_fail++; $display("FAIL rd_load got %h exp 1fffff", cnt_rd); end
        enable = 5'b00001;
        tick();
        enable = '0;
        tick();
        n_checks++;
        if (cnt_rd !== 21'h1F_FFFE) begin n_fail++; $display("FAIL rd_dec got %h exp 1ffffe", cnt_rd); end
        cnt_sel = 3'd7;
        tick();
        n_checks++;
        if (cnt_rd !== 21'h0) begin n_fail++; $display("FAIL rd_out_of_range got %h exp 0", cnt_rd); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_overrun();
        test_zero_load();
        test_two_channel();
        test_init_collision();
        test_abort_and_async_reset();
        test_max_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
